// File: rtl/axi_clint.sv
// axi_clint: AXI4 single-beat responder for the core-local interruptor.
// Exposes a free-running 64-bit mtime as two 32-bit words; R and W FSMs are independent.
module axi_clint #(
    parameter int TICK_DIV = 1,
    parameter int ID_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     araddr,
    input  logic            arvalid,
    output logic            arready,
    input  logic [ID_W-1:0] arid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rvalid,
    input  logic            rready,
    output logic            rlast,
    output logic [ID_W-1:0] rid,
    input  logic [31:0]     awaddr,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wvalid,
    output logic            wready,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    output logic [ID_W-1:0] bid
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [15:0] OFF_LO = 16'h0000;
    localparam logic [15:0] OFF_HI = 16'h0004;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    // Upper address bits are matched by the crossbar.
    logic unused_addr;
    assign unused_addr = ^{araddr[31:16], awaddr[31:16]};

    logic          live;
    logic [63:0]   mtime;
    logic [63:0]   mtime_d;
    logic [63:0]   mtime_wr;
    logic [PW-1:0] presc;
    logic          tick;

    r_state_t      r_state;
    r_state_t      r_next;
    logic          ar_hs;
    logic [31:0]   rd_val;
    logic          rd_err;

    w_state_t      w_state;
    w_state_t      w_next;
    logic          aw_hs;
    logic          w_hs;
    logic          aw_held;
    logic          w_held;
    logic [15:0]   aw_off_q;
    logic [ID_W-1:0] aw_id_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic [15:0]   wr_off;
    logic [ID_W-1:0] wr_id;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          wr_err;
    logic          wr_hi;
    logic          commit;
    logic [31:0]   half_old;
    logic [31:0]   half_new;

    // Readies stay low during reset and rise the cycle after it falls.
    always_ff @(posedge clk) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    // mtime prescaler: one tick every TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    assign tick = (presc == PMAX);

    // A committed write takes precedence over the increment in that cycle.
    always_comb begin
        mtime_d = mtime;
        if (commit && !wr_err) mtime_d = mtime_wr;
        else if (tick)         mtime_d = mtime + 64'd1;
    end

    // mtime register.
    always_ff @(posedge clk) begin
        if (rst) mtime <= '0;
        else     mtime <= mtime_d;
    end

    // ---------------- read channel ----------------

    assign arready = live && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign rlast   = rvalid;
    assign ar_hs   = arvalid && arready;

    // Read address decode against the current (pre-update) mtime.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (araddr[15:0])
            OFF_LO:  rd_val = mtime[31:0];
            OFF_HI:  rd_val = mtime[63:32];
            default: rd_err = 1'b1;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read FSM next-state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read response payload, captured at the AR handshake and held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rresp <= OKAY;
            rid   <= '0;
        end else if (ar_hs) begin
            rdata <= rd_val;
            rresp <= rd_err ? SLVERR : OKAY;
            rid   <= arid;
        end
    end

    // ---------------- write channel ----------------

    assign awready = live && (w_state == W_IDLE) && !aw_held;
    assign wready  = live && (w_state == W_IDLE) && !w_held;
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Merge held beats with those arriving this cycle.
    assign wr_off  = aw_held ? aw_off_q : awaddr[15:0];
    assign wr_id   = aw_held ? aw_id_q  : awid;
    assign wr_data = w_held  ? w_data_q : wdata;
    assign wr_strb = w_held  ? w_strb_q : wstrb;
    assign commit  = (w_state == W_IDLE)
                   && (aw_held || aw_hs)
                   && (w_held || w_hs);

    // Write address decode.
    always_comb begin
        wr_hi  = 1'b0;
        wr_err = 1'b0;
        case (wr_off)
            OFF_LO:  wr_hi = 1'b0;
            OFF_HI:  wr_hi = 1'b1;
            default: wr_err = 1'b1;
        endcase
    end

    // Byte-lane merge into the addressed half of mtime.
    always_comb begin
        half_old = wr_hi ? mtime[63:32] : mtime[31:0];
        half_new = half_old;
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) half_new[8*b +: 8] = wr_data[8*b +: 8];
        end
        mtime_wr = wr_hi ? {half_new, mtime[31:0]}
                         : {mtime[63:32], half_new};
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write FSM next-state.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (commit) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // AW and W holding registers until both halves of the request are present.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_off_q <= '0;
            aw_id_q  <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_off_q <= awaddr[15:0];
                aw_id_q  <= awid;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    // Write response payload, set when the write commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            bresp <= OKAY;
            bid   <= '0;
        end else if (commit) begin
            bresp <= wr_err ? SLVERR : OKAY;
            bid   <= wr_id;
        end
    end

endmodule

// File: tb/tb_axi_clint.sv
// tb_axi_clint: fast (TICK_DIV=1) and slow (TICK_DIV=1000) instances share stimulus.
// A transaction-level model predicts every output; directed cases pin literal values.
module tb_axi_clint;

    localparam int ID_W = 4;
    localparam int SLOW = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] araddr = '0;
    logic arvalid = 1'b0;
    logic [ID_W-1:0] arid = '0;
    logic rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic awvalid = 1'b0;
    logic [ID_W-1:0] awid = '0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic wvalid = 1'b0;
    logic bready = 1'b0;

    logic arready_s [2];
    logic rvalid_s [2];
    logic rlast_s [2];
    logic awready_s [2];
    logic wready_s [2];
    logic bvalid_s [2];
    logic [31:0] rdata_s [2];
    logic [1:0] rresp_s [2];
    logic [1:0] bresp_s [2];
    logic [ID_W-1:0] rid_s [2];
    logic [ID_W-1:0] bid_s [2];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    axi_clint #(.TICK_DIV(1), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_s[0]), .arid(arid),
        .rdata(rdata_s[0]), .rresp(rresp_s[0]), .rvalid(rvalid_s[0]),
        .rready(rready), .rlast(rlast_s[0]), .rid(rid_s[0]),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_s[0]), .awid(awid),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_s[0]),
        .bresp(bresp_s[0]), .bvalid(bvalid_s[0]), .bready(bready), .bid(bid_s[0])
    );

    axi_clint #(.TICK_DIV(SLOW), .ID_W(ID_W)) dut_slow (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_s[1]), .arid(arid),
        .rdata(rdata_s[1]), .rresp(rresp_s[1]), .rvalid(rvalid_s[1]),
        .rready(rready), .rlast(rlast_s[1]), .rid(rid_s[1]),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_s[1]), .awid(awid),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_s[1]),
        .bresp(bresp_s[1]), .bvalid(bvalid_s[1]), .bready(bready), .bid(bid_s[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------

    bit m_live;
    longint unsigned m_mt [2];
    int m_cnt;
    bit m_rbusy;
    logic [31:0] m_rdata [2];
    logic [1:0] m_rresp;
    logic [ID_W-1:0] m_rid;
    bit m_awgot;
    bit m_wgot;
    logic [15:0] m_waddr;
    logic [ID_W-1:0] m_awid;
    logic [31:0] m_wdata;
    logic [3:0] m_wstrb;
    bit m_bpend;
    logic [1:0] m_bresp;
    logic [ID_W-1:0] m_bid;

    function automatic bit mapped(input logic [15:0] off);
        return (off == 16'h0000) || (off == 16'h0004);
    endfunction

    function automatic logic [31:0] word_of(input longint unsigned m, input logic [15:0] off);
        if (off == 16'h0000) return 32'(m);
        if (off == 16'h0004) return 32'(m >> 32);
        return 32'd0;
    endfunction

    function automatic longint unsigned merge(input longint unsigned m, input logic [15:0] off,
                                              input logic [31:0] d, input logic [3:0] s);
        logic [63:0] r;
        int base;
        r = m;
        base = (off == 16'h0004) ? 32 : 0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[base + 8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    initial begin : model
        bit ar_hs;
        bit aw_hs;
        bit w_hs;
        longint unsigned old_mt [2];
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_live = 0; m_mt[0] = 0; m_mt[1] = 0; m_cnt = 0;
                m_rbusy = 0; m_rdata[0] = 0; m_rdata[1] = 0; m_rresp = 0; m_rid = 0;
                m_awgot = 0; m_wgot = 0; m_bpend = 0; m_bresp = 0; m_bid = 0;
            end else begin
                ar_hs = arvalid && m_live && !m_rbusy;
                aw_hs = awvalid && m_live && !m_bpend && !m_awgot;
                w_hs  = wvalid && m_live && !m_bpend && !m_wgot;
                old_mt[0] = m_mt[0];
                old_mt[1] = m_mt[1];
                if (ar_hs) begin
                    m_rbusy = 1;
                    m_rid = arid;
                    m_rresp = mapped(araddr[15:0]) ? 2'b00 : 2'b10;
                    for (int k = 0; k < 2; k++) m_rdata[k] = word_of(old_mt[k], araddr[15:0]);
                end else if (m_rbusy && rready) begin
                    m_rbusy = 0;
                end
                if (m_bpend && bready) m_bpend = 0;
                if (aw_hs) begin
                    m_awgot = 1; m_waddr = awaddr[15:0]; m_awid = awid;
                end
                if (w_hs) begin
                    m_wgot = 1; m_wdata = wdata; m_wstrb = wstrb;
                end
                m_mt[0] = old_mt[0] + 1;
                if (m_cnt == SLOW - 1) begin
                    m_cnt = 0;
                    m_mt[1] = old_mt[1] + 1;
                end else begin
                    m_cnt++;
                end
                if (m_awgot && m_wgot) begin
                    m_awgot = 0; m_wgot = 0; m_bpend = 1; m_bid = m_awid;
                    if (mapped(m_waddr)) begin
                        m_bresp = 2'b00;
                        for (int k = 0; k < 2; k++)
                            m_mt[k] = merge(old_mt[k], m_waddr, m_wdata, m_wstrb);
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
                m_live = 1;
            end
        end
    end

    // Every cycle: compare both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("arready", 64'(arready_s[k]), 64'(m_live && !m_rbusy));
                chk("rvalid", 64'(rvalid_s[k]), 64'(m_rbusy));
                chk("rlast", 64'(rlast_s[k]), 64'(m_rbusy));
                chk("awready", 64'(awready_s[k]), 64'(m_live && !m_bpend && !m_awgot));
                chk("wready", 64'(wready_s[k]), 64'(m_live && !m_bpend && !m_wgot));
                chk("bvalid", 64'(bvalid_s[k]), 64'(m_bpend));
                if (m_rbusy || !m_live) begin
                    chk("rdata", 64'(rdata_s[k]), 64'(m_rdata[k]));
                    chk("rresp", 64'(rresp_s[k]), 64'(m_rresp));
                    chk("rid", 64'(rid_s[k]), 64'(m_rid));
                end
                if (m_bpend || !m_live) begin
                    chk("bresp", 64'(bresp_s[k]), 64'(m_bresp));
                    chk("bid", 64'(bid_s[k]), 64'(m_bid));
                end
            end
        end
    end

    // ---------------- stimulus ----------------

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [ID_W-1:0] id,
                      output logic [31:0] d0, output logic [31:0] d1,
                      output logic [1:0] rs, output int hs);
        int n;
        n = 0;
        araddr = a; arid = id; arvalid = 1'b1; rready = 1'b1;
        while (!arready_s[0] && n < 20) begin
            step();
            n++;
        end
        chk("rd_ar_wait", 64'(arready_s[0]), 64'd1);
        step();
        hs = cyc;
        arvalid = 1'b0;
        chk("rd_latency", 64'(rvalid_s[0]), 64'd1);
        d0 = rdata_s[0]; d1 = rdata_s[1]; rs = rresp_s[0];
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [ID_W-1:0] id, output logic [1:0] bs);
        int n;
        n = 0;
        awaddr = a; awid = id; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(awready_s[0] && wready_s[0]) && n < 20) begin
            step();
            n++;
        end
        chk("wr_ready_wait", 64'(awready_s[0] && wready_s[0]), 64'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid", 64'(bvalid_s[0]), 64'd1);
        bs = bresp_s[0];
        step();
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        logic [15:0] off;
        r = $urandom_range(0, 7);
        if (r < 3)      off = 16'h0000;
        else if (r < 6) off = 16'h0004;
        else if (r < 7) off = 16'h0008;
        else            off = 16'($urandom);
        return {16'($urandom), off};
    endfunction

    initial begin : stim
        logic [31:0] a0, a1, b0, b1;
        logic [1:0] rs, bs;
        int h1, h2;

        step();
        chk_en = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("post_reset_arready", 64'(arready_s[0]), 64'd1);
        chk("post_reset_awready", 64'(awready_s[0]), 64'd1);
        chk("post_reset_wready", 64'(wready_s[0]), 64'd1);

        // Slow instance: mtime still 0, so a byte-lane write is visible alone.
        wr(32'h0200_0000, 32'h0000_AB00, 4'b0010, 4'd1, bs);
        chk("strb_bresp", 64'(bs), 64'd0);
        rd(32'h0200_0000, 4'd2, a0, a1, rs, h1);
        chk("strb_slow_lo", 64'(a1), 64'h0000_AB00);

        // Reset while a write response is pending.
        awaddr = 32'h0200_0004; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF;
        wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("bvalid_pending", 64'(bvalid_s[0]), 64'd1);
        rst = 1'b1;
        step();
        chk("bvalid_rst", 64'(bvalid_s[0]), 64'd0);
        chk("bvalid_rst_slow", 64'(bvalid_s[1]), 64'd0);
        chk("arready_rst", 64'(arready_s[0]), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Two reads exactly 10 cycles apart on the fast counter.
        rd(32'h0200_0000, 4'd4, a0, b0, rs, h1);
        while (cyc < h1 + 9) step();
        rd(32'h0200_0000, 4'd4, a1, b1, rs, h2);
        chk("rd_gap", 64'(h2 - h1), 64'd10);
        chk("mtime_delta", 64'(a1 - a0), 64'd10);
        chk("rd_rresp", 64'(rs), 64'd0);

        // Carry from low into high word.
        wr(32'h0200_0004, 32'h0, 4'hF, 4'd0, bs);
        wr(32'h0200_0000, 32'hFFFF_FFFE, 4'hF, 4'd0, bs);
        repeat (4) step();
        rd(32'h0200_0004, 4'd6, a0, a1, rs, h1);
        chk("carry_hi", 64'(a0), 64'h1);

        // AW three cycles ahead of W.
        awaddr = 32'h0200_0000; awid = 4'd3; awvalid = 1'b1; bready = 1'b1;
        wdata = 32'h100; wstrb = 4'hF;
        step();
        awvalid = 1'b0;
        chk("aw_first_awready", 64'(awready_s[0]), 64'd0);
        chk("aw_first_wready", 64'(wready_s[0]), 64'd1);
        step();
        step();
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("late_w_bvalid", 64'(bvalid_s[0]), 64'd1);
        chk("late_w_bid", 64'(bid_s[0]), 64'd3);
        chk("late_w_bresp", 64'(bresp_s[0]), 64'd0);
        step();

        // Read response stalled for 5 cycles.
        araddr = 32'h0200_0004; arid = 4'd5; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", 64'(rvalid_s[0]), 64'd1);
            chk("stall_arready", 64'(arready_s[0]), 64'd0);
            chk("stall_rid", 64'(rid_s[0]), 64'd5);
            step();
        end
        rready = 1'b1;
        step();
        chk("stall_release", 64'(rvalid_s[0]), 64'd0);

        // Unmapped offset on both channels.
        rd(32'h0200_0008, 4'd7, a0, a1, rs, h1);
        chk("unmapped_rresp", 64'(rs), 64'd2);
        chk("unmapped_rdata", 64'(a0), 64'd0);
        rd(32'h0200_0000, 4'd0, a0, b0, rs, h1);
        wr(32'h0200_0008, 32'h0, 4'hF, 4'd9, bs);
        chk("unmapped_bresp", 64'(bs), 64'd2);
        rd(32'h0200_0000, 4'd0, a1, b1, rs, h2);
        chk("unmapped_no_effect", 64'(a1 - a0), 64'(h2 - h1));

        // Randomized traffic against the model.
        repeat (4000) begin
            arvalid = 1'($urandom);
            araddr = rnd_addr();
            arid = ID_W'($urandom);
            rready = ($urandom_range(0, 3) != 0);
            awvalid = 1'($urandom);
            awaddr = rnd_addr();
            awid = ID_W'($urandom);
            wvalid = 1'($urandom);
            wdata = $urandom;
            wstrb = 4'($urandom);
            bready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end

        rst = 1'b0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
